// File: rtl/game_mode_pkg.sv
// Shared mode encoding and advance-button transition map for the game mode sequencer.
package game_mode_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd1,
        EDIT   = 3'd2,
        DIFF   = 3'd3,
        RUN    = 3'd4,
        PAUSE  = 3'd5,
        FINISH = 3'd6
    } mode_t;

    function automatic mode_t adv_next(input mode_t m);
        case (m)
            IDLE:    adv_next = EDIT;
            EDIT:    adv_next = DIFF;
            DIFF:    adv_next = RUN;
            RUN:     adv_next = PAUSE;
            PAUSE:   adv_next = RUN;
            FINISH:  adv_next = IDLE;
            default: adv_next = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/game_mode_ctrl_btn_edge_sync.sv
// Button synchroniser (STAGES flops) followed by a rising-edge detector giving a 1-cycle pulse.
module btn_edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic btn,
    output logic pulse
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              last_q, last_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], btn};
        last_d = sync_q[STAGES-1];
        pulse  = sync_q[STAGES-1] & ~last_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/game_mode_ctrl.sv
// Game mode sequencer: IDLE->EDIT->DIFF->RUN<->PAUSE plus FINISH, with pause timeout.
// Optional note-count auto-finish is enabled by defining GAME_MODE_AUTO_FINISH_EN.
module game_mode_ctrl
    import game_mode_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned NOTE_W        = 6,
    parameter int unsigned NOTE_LIMIT    = 41,
    parameter int unsigned TMO_W         = 24,
    parameter int unsigned PAUSE_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              btn_adv,
    input  logic              btn_quit,
    input  logic [NOTE_W-1:0] note_count,
    output logic [2:0]        mode,
    output logic              mode_changed,
    output logic [2:0]        prev_mode,
    output logic              run_en
);

    localparam bit               TMO_EN   = (PAUSE_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PAUSE_TIMEOUT - 1);

    logic adv_pulse, quit_pulse;

    btn_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_adv (
        .clk   (clk),
        .n_rst (n_rst),
        .btn   (btn_adv),
        .pulse (adv_pulse)
    );

    btn_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_quit (
        .clk   (clk),
        .n_rst (n_rst),
        .btn   (btn_quit),
        .pulse (quit_pulse)
    );

    mode_t            mode_q, mode_d;
    mode_t            prev_q, prev_d;
    logic             changed_q, changed_d;
    logic             run_en_q, run_en_d;
    logic [TMO_W-1:0] timer_q, timer_d;
    logic             tmo_hit;
    logic             note_hit;

`ifdef GAME_MODE_AUTO_FINISH_EN
    assign note_hit = (note_count == NOTE_W'(NOTE_LIMIT));
`else
    logic unused_note;
    assign unused_note = ^{note_count, NOTE_W'(NOTE_LIMIT)};
    assign note_hit    = 1'b0;
`endif

    always_comb begin
        mode_d  = mode_q;
        tmo_hit = TMO_EN && (mode_q == PAUSE) && (timer_q == TMO_LAST);

        if (!(mode_q inside {IDLE, EDIT, DIFF, RUN, PAUSE, FINISH}))
            mode_d = IDLE;
        else if (quit_pulse)
            mode_d = FINISH;
        else if (adv_pulse)
            mode_d = adv_next(mode_q);
        else if (tmo_hit)
            mode_d = FINISH;
        else if (note_hit && mode_q == RUN)
            mode_d = FINISH;

        // Timer only runs while staying in PAUSE, so it always starts from 0 on entry.
        timer_d = '0;
        if (TMO_EN && mode_q == PAUSE && mode_d == PAUSE)
            timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;

        changed_d = (mode_d != mode_q);
        prev_d    = changed_d ? mode_q : prev_q;
        run_en_d  = (mode_d == RUN);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mode_q    <= IDLE;
            prev_q    <= IDLE;
            changed_q <= 1'b0;
            run_en_q  <= 1'b0;
            timer_q   <= '0;
        end else begin
            mode_q    <= mode_d;
            prev_q    <= prev_d;
            changed_q <= changed_d;
            run_en_q  <= run_en_d;
            timer_q   <= timer_d;
        end
    end

    assign mode         = mode_q;
    assign prev_mode    = prev_q;
    assign mode_changed = changed_q;
    assign run_en       = run_en_q;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Scoreboard bench for game_mode_ctrl: expected transitions queued at stimulus, checked on each strobe.
module tb_game_mode_ctrl;
    import game_mode_pkg::*;

    localparam int unsigned SYNC = 2;
    localparam int unsigned TMO  = 10;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       btn_adv, btn_quit;
    logic [5:0] note_count;
    logic [2:0] mode, prev_mode;
    logic       mode_changed, run_en;

    game_mode_ctrl #(
        .SYNC_STAGES   (SYNC),
        .NOTE_W        (6),
        .NOTE_LIMIT    (41),
        .TMO_W         (24),
        .PAUSE_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .btn_adv      (btn_adv),
        .btn_quit     (btn_quit),
        .note_count   (note_count),
        .mode         (mode),
        .mode_changed (mode_changed),
        .prev_mode    (prev_mode),
        .run_en       (run_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] prev;
        logic [2:0] nxt;
    } sb_ent_t;

    sb_ent_t    sb[$];
    sb_ent_t    ent;
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_strobe = 0;
    logic [2:0] cur_mode;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every strobe must match the oldest queued transition
    always @(negedge clk) begin
        if (n_rst === 1'b1 && mode_changed === 1'b1) begin
            n_strobe++;
            chk("sb_pending", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                ent = sb.pop_front();
                chk("sb_prev", prev_mode, ent.prev);
                chk("sb_mode", mode, ent.nxt);
            end
        end
    end

    task automatic press(input logic a, input logic q, input logic [2:0] exp, input string tag);
        if (exp != cur_mode) sb.push_back('{cur_mode, exp});
        btn_adv  = a;
        btn_quit = q;
        for (int i = 0; i <= SYNC; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_mode"}, mode, (i < SYNC) ? cur_mode : exp);
        end
        chk({tag, "_run_en"}, run_en, exp == RUN);
        cur_mode = exp;
        btn_adv  = 1'b0;
        btn_quit = 1'b0;
        repeat (SYNC + 1) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s0;
        n_rst      = 1'b0;
        btn_adv    = 1'b0;
        btn_quit   = 1'b0;
        note_count = '0;
        cur_mode   = IDLE;
        repeat (3) @(negedge clk);
        chk("rst_mode", mode, IDLE);
        chk("rst_prev", prev_mode, IDLE);
        chk("rst_strobe", mode_changed, 0);
        chk("rst_run_en", run_en, 0);
        n_rst = 1'b1;
        @(negedge clk);

        // Walk IDLE->EDIT->DIFF->RUN->PAUSE
        press(1, 0, EDIT,  "adv1");
        press(1, 0, DIFF,  "adv2");
        press(1, 0, RUN,   "adv3");
        press(1, 0, PAUSE, "adv4");
        chk("strobes_walk", n_strobe, 4);

        // Resume before timeout, then pause and let it expire
        press(1, 0, RUN, "resume");
        repeat (12) @(negedge clk);
        chk("run_kept", mode, RUN);
        press(1, 0, PAUSE, "pause2");
        sb.push_back('{PAUSE, FINISH});
        for (int k = SYNC + 2; k <= TMO; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("tmo_mode", mode, (k < TMO) ? PAUSE : FINISH);
        end
        cur_mode = FINISH;

        press(1, 0, IDLE, "fin_adv");

        // Held button: one transition only
        s0 = n_strobe;
        sb.push_back('{IDLE, EDIT});
        btn_adv = 1'b1;
        repeat (100) @(negedge clk);
        chk("hold_mode", mode, EDIT);
        chk("hold_strobes", n_strobe - s0, 1);
        btn_adv  = 1'b0;
        cur_mode = EDIT;
        repeat (SYNC + 1) @(negedge clk);

        press(1, 0, DIFF, "to_diff");
        press(1, 0, RUN,  "to_run");
        press(1, 1, FINISH, "adv_quit");
        s0 = n_strobe;
        press(0, 1, FINISH, "quit_fin");
        chk("quit_fin_strobes", n_strobe - s0, 0);

        press(1, 0, IDLE, "r1");
        press(1, 0, EDIT, "r2");
        press(1, 0, DIFF, "r3");
        press(1, 0, RUN,  "r4");

        // Asynchronous reset mid-RUN
        n_rst = 1'b0;
        #1;
        chk("arst_mode", mode, IDLE);
        chk("arst_run_en", run_en, 0);
        chk("arst_strobe", mode_changed, 0);
        chk("arst_prev", prev_mode, IDLE);
        @(negedge clk);
        n_rst    = 1'b1;
        cur_mode = IDLE;
        @(negedge clk);

        press(1, 0, EDIT, "s1");
        press(1, 0, DIFF, "s2");
        press(1, 0, RUN,  "s3");

        note_count = 6'd40;
        @(posedge clk);
        @(negedge clk);
        chk("note40_mode", mode, RUN);
        note_count = 6'd41;
`ifdef GAME_MODE_AUTO_FINISH_EN
        sb.push_back('{RUN, FINISH});
        @(posedge clk);
        @(negedge clk);
        chk("note41_mode", mode, FINISH);
`else
        @(posedge clk);
        @(negedge clk);
        chk("note41_mode", mode, RUN);
        repeat (3) @(negedge clk);
        chk("note41_hold", mode, RUN);
`endif
        note_count = '0;
        repeat (2) @(negedge clk);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
